// File: rtl/lsu_pkg.sv
// Shared store-path definitions: store opcode, funct3 size encodings and the misalignment predicate.
package lsu_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    SZ_B = 3'b000,
    SZ_H = 3'b001,
    SZ_W = 3'b010,
    SZ_D = 3'b011
  } store_size_e;

  // off is the byte offset zero-extended to 3 bits so one predicate serves XLEN 32 and 64
  function automatic logic store_misaligned(input logic [2:0] f3, input logic [2:0] off);
    logic m;
    m = 1'b0;
    case (f3)
      SZ_H:    m = off[0];
      SZ_W:    m = (off[1:0] != 2'b00);
      SZ_D:    m = (off != 3'b000);
      default: m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/store_fifo.sv
// Generic DEPTH x WIDTH FIFO; the head reads as zero while empty so consumers see a clean idle bus.
module store_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // storage needs no reset: contents are only observable through a non-zero count
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/store_buffer_unit.sv
// S-type store decode, address add and lane steering feeding a drain FIFO toward dmem.
// Optional macro STORE_MISALIGN_TRAP_EN: reject misaligned stores with a misalign pulse instead of aligning them.
module store_buffer_unit
  import lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        funct3,
  input  logic [11:0]       imm,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  output logic              dmem_req,
  input  logic              dmem_gnt,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [XLEN/8-1:0] dmem_be,
  output logic              misalign,
  output logic              buf_empty
);

  localparam int NB    = XLEN / 8;
  localparam int OB    = $clog2(NB);
  localparam int WIDTH = 2*XLEN + NB;

  logic [XLEN-1:0]        ea;
  logic [2:0]             off3, off_eff;
  logic                   f3_legal, acc, push;
  logic                   full, empty;
  logic [NB-1:0][7:0]     wdata_lanes;
  logic [NB-1:0]          be;
  logic [WIDTH-1:0]       din, head;

  assign ea       = rs1_data + {{(XLEN-12){imm[11]}}, imm};
  assign f3_legal = (funct3 == SZ_B) || (funct3 == SZ_H) || (funct3 == SZ_W) ||
                    ((funct3 == SZ_D) && (XLEN == 64));
  assign acc      = st_valid && st_ready && (opcode == OPC_STORE) && f3_legal;

  always_comb begin
    off3         = '0;
    off3[OB-1:0] = ea[OB-1:0];
  end

`ifdef STORE_MISALIGN_TRAP_EN
  logic mis, misalign_q;

  assign mis     = store_misaligned(funct3, off3);
  assign off_eff = off3;
  assign push    = acc && !mis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= acc && mis;
  end
  assign misalign = misalign_q;
`else
  // offset bits below the access size are dropped so the store lands naturally aligned
  always_comb begin
    case (funct3)
      SZ_B:    off_eff = off3;
      SZ_H:    off_eff = {off3[2:1], 1'b0};
      SZ_W:    off_eff = {off3[2], 2'b00};
      default: off_eff = 3'b000;
    endcase
  end
  assign push     = acc;
  assign misalign = 1'b0;
`endif

  for (genvar i = 0; i < NB; i++) begin : g_lane
    always_comb begin
      case (funct3)
        SZ_B:    wdata_lanes[i] = rs2_data[7:0];
        SZ_H:    wdata_lanes[i] = rs2_data[8*(i%2) +: 8];
        SZ_W:    wdata_lanes[i] = rs2_data[8*(i%4) +: 8];
        default: wdata_lanes[i] = rs2_data[8*i +: 8];
      endcase
    end
  end

  always_comb begin
    case (funct3)
      SZ_B:    be = NB'(1)  << off_eff;
      SZ_H:    be = NB'(3)  << off_eff;
      SZ_W:    be = NB'(15) << off_eff;
      default: be = '1;
    endcase
  end

  assign din = {ea[XLEN-1:OB], {OB{1'b0}}, wdata_lanes, be};

  store_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (dmem_req && dmem_gnt),
    .din   (din),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // all handshake outputs come from FIFO state, never from st_valid or dmem_gnt
  assign st_ready  = !full;
  assign buf_empty = empty;
  assign dmem_req  = !empty;
  assign {dmem_addr, dmem_wdata, dmem_be} = head;

endmodule

// File: tb/tb_store_buffer_unit.sv
// Directed bench for store_buffer_unit (XLEN=32, DEPTH=4) with a drain-side scoreboard.
module tb_store_buffer_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [11:0] imm;
  logic [31:0] rs1_data, rs2_data;
  logic        dmem_req, dmem_gnt;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        misalign, buf_empty;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  store_buffer_unit #(.XLEN(32), .DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .st_valid   (st_valid),
    .st_ready   (st_ready),
    .opcode     (opcode),
    .funct3     (funct3),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .dmem_req   (dmem_req),
    .dmem_gnt   (dmem_gnt),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .misalign   (misalign),
    .buf_empty  (buf_empty)
  );

  // drain-side scoreboard: every granted head must match the oldest expected store
  always @(negedge clk) begin
    if (rst_n && dmem_req && dmem_gnt) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        assert (1'b0) else begin
          fails++;
          $error("FAIL drain_unexpected addr=%0h (no store expected)", dmem_addr);
        end
      end else begin
        e = exp_q.pop_front();
        assert (dmem_addr === e.a && dmem_wdata === e.d && dmem_be === e.be) else begin
          fails++;
          $error("FAIL drain got a=%0h d=%0h be=%0h want a=%0h d=%0h be=%0h",
                 dmem_addr, dmem_wdata, dmem_be, e.a, e.d, e.be);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] r1,
                       input logic [11:0] im, input logic [31:0] r2);
    st_valid = 1'b1;
    opcode   = opc;
    funct3   = f3;
    rs1_data = r1;
    imm      = im;
    rs2_data = r2;
  endtask

  task automatic expect_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    exp_t e;
    e.a = a; e.d = d; e.be = be;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_n = 1'b0; st_valid = 1'b0; dmem_gnt = 1'b0;
    opcode = '0; funct3 = '0; imm = '0; rs1_data = '0; rs2_data = '0;
    #12;
    chk("rst_req",   dmem_req,  1'b0);
    chk("rst_ready", st_ready,  1'b1);
    chk("rst_empty", buf_empty, 1'b1);
    chk("rst_mis",   misalign,  1'b0);
    chk("rst_bus",   {dmem_addr, dmem_wdata, dmem_be}, '0);
    rst_n = 1'b1;
    step();

    // SW with one-cycle latency to dmem_req
    dmem_gnt = 1'b1;
    drive(7'b0100011, 3'b010, 32'h1000, 12'h004, 32'hDEADBEEF);
    expect_st(32'h1004, 32'hDEADBEEF, 4'hF);
    step();
    st_valid = 1'b0;
    chk("sw_latency_req", dmem_req, 1'b1);
    step();
    chk("sw_drained_empty", buf_empty, 1'b1);

    // byte and halfword lane steering, back to back
    drive(7'b0100011, 3'b000, 32'h2003, 12'h000, 32'h000000A5);
    expect_st(32'h2000, 32'hA5A5A5A5, 4'b1000);
    step();
    drive(7'b0100011, 3'b001, 32'h2002, 12'h000, 32'h00001234);
    expect_st(32'h2000, 32'h12341234, 4'b1100);
    step();
    // negative immediate
    drive(7'b0100011, 3'b010, 32'h0100, 12'hFFC, 32'h11223344);
    expect_st(32'h00FC, 32'h11223344, 4'hF);
    step();
    st_valid = 1'b0;
    step(); step();
    chk("steer_drained", exp_q.size(), 0);

    // fill with grant held low
    dmem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(7'b0100011, 3'b010, 32'h4000 + 32'(i*4), 12'h000, 32'hC0DE0000 + 32'(i));
      expect_st(32'h4000 + 32'(i*4), 32'hC0DE0000 + 32'(i), 4'hF);
      step();
    end
    chk("full_ready", st_ready, 1'b0);
    drive(7'b0100011, 3'b010, 32'h5000, 12'h000, 32'hBAD0BAD0);
    step(); step();
    chk("full_held_ready", st_ready, 1'b0);
    st_valid = 1'b0;
    dmem_gnt = 1'b1;
    #1;
    chk("gnt_no_comb_ready", st_ready, 1'b0);
    step();
    chk("ready_after_pop", st_ready, 1'b1);
    begin
      int n = 0;
      while (!buf_empty && n < 20) begin step(); n++; end
      chk("full_drain_bound", buf_empty, 1'b1);
    end
    chk("full_drain_count", exp_q.size(), 0);

    // misaligned SW at 0x3002
`ifdef STORE_MISALIGN_TRAP_EN
    drive(7'b0100011, 3'b010, 32'h3000, 12'h002, 32'h55667788);
    step();
    st_valid = 1'b0;
    chk("mis_pulse", misalign, 1'b1);
    chk("mis_no_enq", buf_empty, 1'b1);
    step();
    chk("mis_pulse_end", misalign, 1'b0);
`else
    drive(7'b0100011, 3'b010, 32'h3000, 12'h002, 32'h55667788);
    expect_st(32'h3000, 32'h55667788, 4'hF);
    step();
    st_valid = 1'b0;
    chk("mis_enq_req", dmem_req, 1'b1);
    chk("mis_tied0", misalign, 1'b0);
    step(); step();
`endif
    chk("mis_drained", exp_q.size(), 0);

    // non-store opcode and SD on XLEN=32 are ignored
    drive(7'b0110011, 3'b010, 32'h6000, 12'h000, 32'h1);
    step();
    drive(7'b0100011, 3'b011, 32'h6000, 12'h000, 32'h2);
    step();
    st_valid = 1'b0;
    chk("illegal_no_enq", buf_empty, 1'b1);
    chk("illegal_no_mis", misalign, 1'b0);

    // asynchronous reset with 3 pending
    dmem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(7'b0100011, 3'b010, 32'h7000 + 32'(i*4), 12'h000, 32'h0);
      step();
    end
    st_valid = 1'b0;
    chk("pend_req", dmem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req",   dmem_req,  1'b0);
    chk("async_rst_empty", buf_empty, 1'b1);
    chk("async_rst_ready", st_ready,  1'b1);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", buf_empty, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer_unit.md
# store_buffer_unit

Parametrised store path that replaces the single-cycle combinational store decoder. It decodes RISC-V S-type stores, computes the effective address, steers data onto the correct byte lanes, and queues each store in a DEPTH-entry FIFO. Entries drain to data memory over a req/gnt handshake, so the core does not stall on memory latency. It sits between the execute stage and the dmem port.

## Interface
- XLEN, 32, data/address width; 32 or 64 only.
- DEPTH, 4, store buffer entries; power of two, ≥2.

- clk  in  1  clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- st_valid  in  1  execute stage presents an instruction
- st_ready  out  1  buffer can accept a store (not full)
- opcode  in  7  instruction opcode
- funct3  in  3  store size
- imm  in  12  S-type immediate
- rs1_data  in  XLEN  base address
- rs2_data  in  XLEN  store data
- dmem_req  out  1  head entry valid toward dmem
- dmem_gnt  in  1  dmem accepts head entry this cycle
- dmem_addr  out  XLEN  lane-aligned address (low log2(XLEN/8) bits zero)
- dmem_wdata  out  XLEN  lane-replicated store data
- dmem_be  out  XLEN/8  byte enables
- misalign  out  1  one-cycle pulse for a rejected misaligned store
- buf_empty  out  1  no pending stores

## Operation
- Accept: st_valid && st_ready && opcode==7'b0100011 && funct3 legal. Legal funct3 values are 000 SB, 001 SH, 010 SW, and 011 SD when XLEN==64 only. Anything else is ignored: no enqueue and no pulse.
- ea = rs1_data + sign-extended imm, modulo 2^XLEN. off = ea[log2(XLEN/8)-1:0].
- Data replication:
  - SB: byte replicated across all lanes; be = 1<<off.
  - SH: halfword replicated; be = 2'b11<<off.
  - SW: word replicated; be = 4'hF<<off.
  - SD: be = all ones.
- Stored entry = {ea with off zeroed, replicated data, be}.
- Misaligned: SH with off[0]==1; SW with off[1:0]!=0; SD with off!=0. Handling depends on the macro (see Configuration).
- Drain:
  - While the buffer is non-empty, dmem_req=1 and dmem_addr/dmem_wdata/dmem_be show the head entry.
  - The head entry holds stable until dmem_gnt. On dmem_req&&dmem_gnt the entry pops.
  - When empty, dmem_req=0 and dmem_addr/dmem_wdata/dmem_be=0. dmem_gnt is ignored.
- Entries leave strictly in FIFO order. There is no merging or forwarding.
- Full: st_ready=0. A pop in the same cycle does not allow a push; st_ready re-rises the cycle after the pop.
- Simultaneous push and pop when neither full nor empty: the count is unchanged and both operations occur.
- Read/write pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.

## Timing
- Reset values: pointers and count 0, dmem_req 0, dmem_addr/dmem_wdata/dmem_be 0, st_ready 1, buf_empty 1, misalign 0.
- Latency: a store accepted in cycle N appears on dmem_req in cycle N+1 if the buffer was empty.
- Throughput: one accept and one drain per cycle.
- st_ready, buf_empty, and dmem_* are functions of registered state only. There is no combinational path from st_valid or dmem_gnt.
- misalign is registered: it asserts in cycle N+1 for a rejection in cycle N, for exactly one cycle.
- Reset asserted mid-operation discards all buffered stores immediately. dmem_req drops asynchronously.

## Configuration
- STORE_MISALIGN_TRAP_EN defined: a misaligned store is not enqueued, misalign pulses, and st_ready is unaffected.
- STORE_MISALIGN_TRAP_EN undefined: off bits below the access size are forced to zero before lane steering and the store is enqueued. misalign is tied 0.

## Structure
- Package lsu_pkg holds:
  - OPC_STORE
  - enum store_size_e (SB/SH/SW/SD with funct3 encodings)
  - the misalign predicate function
- Sub-module store_fifo: generic DEPTH×WIDTH FIFO with push/pop/full/empty. The top-level instantiates it with WIDTH = 2*XLEN + XLEN/8.
- Decode, address add, and lane steering stay in the top level.

## Test plan
- Reset, then SW with rs1=0x1000, imm=0x004, rs2=0xDEADBEEF, and dmem_gnt=1 → next cycle dmem_req=1, addr=0x1004, wdata=0xDEADBEEF, be=4'hF. Then buf_empty=1.
- SB with rs1=0x2003, imm=0, rs2=0x000000A5 → addr=0x2000, wdata=0xA5A5A5A5, be=4'b1000. SH with ea=0x2002 → be=4'b1100.
- Negative imm=0xFFC with rs1=0x100 → addr=0x0FC.
- dmem_gnt held 0 while 4 SW issued (DEPTH=4) → st_ready=0 after the 4th. A 5th store is held off. Release gnt → FIFO-order drain of all 4, and st_ready returns the cycle after the first pop.
- SW with ea=0x3002:
  - With STORE_MISALIGN_TRAP_EN → misalign pulses 1 cycle and nothing is enqueued.
  - Without it → addr=0x3000, be=4'hF.
- opcode=0110011 with st_valid=1 → no enqueue. Then assert rst_n=0 with 3 entries pending → dmem_req=0, buf_empty=1 without waiting for a clock edge.
